// File: rtl/regfile_dump_reader.sv
// Walks the register file's spare combinational read port and streams every register out over valid/ready.
// Optional trailing XOR checksum word is enabled by defining REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump_reader #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] ctrl_readReg,
    input  logic [DATA_WIDTH-1:0] data_readReg,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE = 3'd0, READ = 3'd1, SEND = 3'd2, CSUM = 3'd3, DONE = 3'd4} state_t;

    function automatic logic [DATA_WIDTH-1:0] csum_update(input logic [DATA_WIDTH-1:0] acc,
                                                          input logic [DATA_WIDTH-1:0] word);
        return acc ^ word;
    endfunction
`else
    typedef enum logic [2:0] {IDLE = 3'd0, READ = 3'd1, SEND = 3'd2, DONE = 3'd4} state_t;
`endif

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [DATA_WIDTH-1:0]   data_r, data_s;
    logic [ADDR_WIDTH-1:0]   oaddr_r, oaddr_s;
    logic                    valid_r, valid_s;
    logic                    last_r, last_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;
    logic                    accept_s;
    logic                    last_reg_s;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   acc_r, acc_s;
`endif

    // Next-state and next-output decode; abort overrides any handshake completing this cycle.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        data_s     = data_r;
        oaddr_s    = oaddr_r;
        valid_s    = valid_r;
        last_s     = last_r;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        acc_s      = acc_r;
`endif
        accept_s   = valid_r & out_ready;
        last_reg_s = (addr_r == LAST_ADDR);

        if (abort && (state_r != IDLE)) begin
            state_s = IDLE;
            addr_s  = ZERO_ADDR;
            valid_s = 1'b0;
            last_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !abort) begin
                        state_s = READ;
                        addr_s  = ZERO_ADDR;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        acc_s   = ZERO_DATA;
`endif
                    end else begin
                        state_s = IDLE;
                    end
                end
                READ: begin
                    data_s  = data_readReg;
                    oaddr_s = addr_r;
                    valid_s = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    last_s  = 1'b0;
`else
                    last_s  = last_reg_s;
`endif
                    state_s = SEND;
                end
                SEND: begin
                    if (accept_s) begin
                        valid_s = 1'b0;
                        last_s  = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        acc_s   = csum_update(acc_r, data_r);
`endif
                        if (last_reg_s) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            data_s  = acc_s;
                            oaddr_s = ZERO_ADDR;
                            valid_s = 1'b1;
                            last_s  = 1'b1;
                            state_s = CSUM;
`else
                            state_s = DONE;
`endif
                        end else begin
                            addr_s  = addr_r + ONE_ADDR;
                            state_s = READ;
                        end
                    end else begin
                        state_s = SEND;
                    end
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                CSUM: begin
                    if (accept_s) begin
                        valid_s = 1'b0;
                        last_s  = 1'b0;
                        state_s = DONE;
                    end else begin
                        state_s = CSUM;
                    end
                end
`endif
                DONE: begin
                    state_s = IDLE;
                    addr_s  = ZERO_ADDR;
                end
                default: begin
                    state_s = IDLE;
                    addr_s  = ZERO_ADDR;
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                end
            endcase
        end

        busy_s = (state_s != IDLE) && (state_s != DONE);
        done_s = (state_s == DONE);
    end

    // State and registered-output update.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_r <= IDLE;
            addr_r  <= ZERO_ADDR;
            data_r  <= ZERO_DATA;
            oaddr_r <= ZERO_ADDR;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_r   <= ZERO_DATA;
`endif
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            data_r  <= data_s;
            oaddr_r <= oaddr_s;
            valid_r <= valid_s;
            last_r  <= last_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_r   <= acc_s;
`endif
        end
    end

    assign ctrl_readReg = addr_r;
    assign out_data     = data_r;
    assign out_addr     = oaddr_r;
    assign out_valid    = valid_r;
    assign out_last     = last_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table of dump scenarios checked against a word-list model, plus
// hand-written reset, abort, start-while-busy and mid-dump reset sequences.
module tb_regfile_dump_reader;
    localparam int N  = 32;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int WORDS = N + CS;

    logic          clock = 1'b0;
    logic          ctrl_reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] ctrl_readReg;
    logic [DW-1:0] data_readReg;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid, out_last, busy, done;
    logic [DW-1:0] regs [N];

    regfile_dump_reader #(.NUM_REGS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n), .start(start), .abort(abort),
        .ctrl_readReg(ctrl_readReg), .data_readReg(data_readReg),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    assign data_readReg = regs[ctrl_readReg];
    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    typedef struct {
        int            pattern;
        int            ready_pct;
        bit            inject_start;
        logic [AW-1:0] stall_addr;
        int            stall_len;
        int            exp_words;
        int            exp_done;
    } vec_t;

    word_t         got[$];
    word_t         exp_q[$];
    int            tests = 0;
    int            fails = 0;
    int            done_cnt, busy_cycles, cyc, last_acc_cyc, done_cyc;
    int            ready_pct = 100;
    int            stall_len = 0;
    int            stall_used = 0;
    logic [AW-1:0] stall_addr = '0;
    bit            prev_hold = 1'b0;
    word_t         prev_w;
    vec_t          vecs[6];
    bit            ok;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({ctrl_readReg, out_data, out_addr, out_valid, out_last, busy, done}), 64'd0);
    endtask

    // One clock: observe at the falling edge, then choose out_ready just after the rising edge.
    task automatic step();
        word_t w;
        @(negedge clock);
        cyc++;
        w = '{addr: out_addr, data: out_data, last: out_last};
        if (ctrl_reset_n) begin
            if (busy) busy_cycles++;
            if (done) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
                check("busy_in_done", 64'(busy), 64'd0);
            end
            if (prev_hold) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_word", 64'(w), 64'(prev_w));
            end
            prev_hold = out_valid && !out_ready && !abort;
            prev_w    = w;
            if (out_valid && out_ready && !abort) begin
                got.push_back(w);
                if (out_last) last_acc_cyc = cyc;
            end
        end else begin
            prev_hold = 1'b0;
        end
        @(posedge clock);
        #1;
        if (out_valid && out_addr == stall_addr && stall_used < stall_len) begin
            out_ready = 1'b0;
            stall_used++;
        end else begin
            out_ready = (int'($urandom_range(0, 99)) < ready_pct);
            if (out_addr != stall_addr) stall_used = 0;
        end
    endtask

    task automatic fill(input int p);
        for (int i = 0; i < N; i++) begin
            case (p)
                0:       regs[i] = 32'hA500_0000 + 32'(i);
                1:       regs[i] = $urandom;
                2:       regs[i] = (i == 5) ? 32'hFFFF_FFFF : 32'hA500_0000 + 32'(i);
                3:       regs[i] = 32'hFFFF_FFFF;
                default: regs[i] = 32'h0000_0000;
            endcase
        end
    endtask

    // Expected stream: each register in order, then the XOR of all of them when checksumming.
    task automatic build_expected();
        logic [DW-1:0] acc;
        acc = '0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            exp_q.push_back('{addr: AW'(i), data: regs[i], last: (CS == 0) && (i == N - 1)});
            acc = acc ^ regs[i];
        end
        if (CS == 1) exp_q.push_back('{addr: '0, data: acc, last: 1'b1});
    endtask

    task automatic start_dump();
        got.delete();
        done_cnt = 0; busy_cycles = 0; last_acc_cyc = -100; done_cyc = -1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit inject, output bit done_ok);
        done_ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (done_cnt > 0) begin
                done_ok = 1'b1;
                break;
            end
            start = inject && busy && (out_addr == 5'd3);
            step();
        end
        start = 1'b0;
        check("done_timeout", 64'(done_ok), 64'd1);
    endtask

    task automatic compare_words(input string tag, input int exp_words);
        check({tag, "_count"}, 64'(got.size()), 64'(exp_words));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check({tag, "_word"}, 64'(got[i]), 64'(exp_q[i]));
    endtask

    initial begin
        cyc = 0; done_cnt = 0; busy_cycles = 0;
        fill(0);

        // Reset held three cycles, then idle with no start.
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("in_reset");
        ctrl_reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_all_zero("idle");
        end

        vecs[0] = '{0, 100, 1'b0, 5'd0,  0, WORDS, 1};
        vecs[1] = '{0, 100, 1'b0, 5'd7,  5, WORDS, 1};
        vecs[2] = '{1, 60,  1'b0, 5'd0,  0, WORDS, 1};
        vecs[3] = '{2, 100, 1'b1, 5'd0,  0, WORDS, 1};
        vecs[4] = '{3, 30,  1'b0, 5'd31, 4, WORDS, 1};
        vecs[5] = '{4, 100, 1'b0, 5'd0,  0, WORDS, 1};

        foreach (vecs[v]) begin
            fill(vecs[v].pattern);
            ready_pct  = vecs[v].ready_pct;
            stall_addr = vecs[v].stall_addr;
            stall_len  = vecs[v].stall_len;
            stall_used = 0;
            build_expected();
            start_dump();
            wait_done(vecs[v].inject_start, ok);
            repeat (3) step();
            compare_words("dump", vecs[v].exp_words);
            check("done_count", 64'(done_cnt), 64'(vecs[v].exp_done));
            check("done_latency", 64'(done_cyc - last_acc_cyc), 64'd1);
            if (vecs[v].ready_pct == 100 && vecs[v].stall_len == 0)
                check("busy_cycles", 64'(busy_cycles), 64'(2 * N + CS));
            check("idle_after", 64'({busy, out_valid, ctrl_readReg}), 64'd0);
        end
        stall_len = 0;
        ready_pct = 100;

        // start together with abort in IDLE stays idle.
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 64'({busy, out_valid}), 64'd0);
        step();
        check("start_abort_idle2", 64'({busy, out_valid}), 64'd0);

        // start presented during the DONE cycle is ignored.
        fill(0);
        start_dump();
        for (int c = 0; c < 400 && !done; c++) step();
        check("reached_done", 64'(done), 64'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_in_done", 64'({busy, out_valid}), 64'd0);
        step();
        check("start_in_done2", 64'(busy), 64'd0);

        // Abort while word 12 is offered and accepted in the same cycle.
        start_dump();
        for (int c = 0; c < 400 && !(out_valid && out_addr == 5'd12); c++) step();
        check("reach_w12", 64'({out_valid, out_addr}), 64'({1'b1, 5'd12}));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_outputs", 64'({out_valid, out_last, busy, ctrl_readReg}), 64'd0);
        repeat (3) step();
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_words", 64'(got.size()), 64'd12);
        build_expected();
        start_dump();
        wait_done(1'b0, ok);
        compare_words("restart", WORDS);

        // Asynchronous reset in the middle of word 20.
        start_dump();
        for (int c = 0; c < 400 && !(out_valid && out_addr == 5'd20); c++) step();
        check("reach_w20", 64'({out_valid, out_addr}), 64'({1'b1, 5'd20}));
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) step();
        check("reset_no_done", 64'(done_cnt), 64'd0);
        @(posedge clock);
        #1;
        ctrl_reset_n = 1'b1;
        repeat (2) step();
        check_all_zero("after_reset_idle");
        start_dump();
        wait_done(1'b0, ok);
        compare_words("post_reset", WORDS);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
